// File: rtl/ff256_mult_seq.sv
// ff256_mult_seq
//   Batch sequencer for a GF(256) multiplier datapath. It walks a block of
//   operand words in a dual-port RAM through a Wishbone-style master port.
//   For each word it reads the operand bytes ([7:0] = f, [15:8] = p), presents
//   them to an external combinational GF(256) multiplier, and writes the
//   product back into byte lane 2 ([23:16]) of the same word.
//
//   Optional feature macro: FF256_SEQ_ACCUM_EN
//     defined     -> acc_o keeps the XOR of all products written in the batch
//                    (a GF(256) dot product); cleared on the next accepted start.
//     not defined -> acc_o is tied to zero and no accumulator register exists.
//
// Ports
//   clk, reset          : clock (rising edge), synchronous active-high reset
//   start_i             : start level, sampled only in IDLE
//   base_adr_i, count_i : first element address / element count, latched on start
//   mem_adr_o .. mem_ack_i : RAM port-2 bus master (adr, wdata, we, sel, stb, cyc, rdata, ack)
//   mul_f_o, mul_p_o    : multiplier operands (always the operand register)
//   mul_prod_i          : multiplier product (combinational)
//   busy_o, done_o      : not-IDLE flag / one-cycle end-of-batch pulse
//   err_o               : sticky ack-timeout flag
//   state_o             : FSM state (IDLE=0 READ=1 MULT=2 WRITE=3 DONE=4)
//   acc_o               : XOR accumulation of products (see macro above)
module ff256_mult_seq #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_adr_i,
  input  logic [ADDR_WIDTH:0]     count_i,
  output logic [ADDR_WIDTH-1:0]   mem_adr_o,
  input  logic [DATA_WIDTH-1:0]   mem_data_i,
  output logic [DATA_WIDTH-1:0]   mem_data_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_sel_o,
  output logic                    mem_stb_o,
  output logic                    mem_cyc_o,
  input  logic                    mem_ack_i,
  output logic [7:0]              mul_f_o,
  output logic [7:0]              mul_p_o,
  input  logic [7:0]              mul_prod_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [2:0]              state_o,
  output logic [7:0]              acc_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MULT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int                 SEL_W   = DATA_WIDTH / 8;
  localparam logic [SEL_W-1:0]   SEL_WR  = SEL_W'(3'b100);
  localparam logic [3:0]         TO_LAST = 4'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH:0] ONE_LEFT = (ADDR_WIDTH + 1)'(1);

  state_t                state, state_next;
  logic [3:0]            tmo_cnt;
  logic                  tmo_hit;
  logic                  bus_rd, bus_wr;
  logic                  start_ok;
  logic                  err;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   remain;
  logic [15:0]           opnd_p0;
  logic [7:0]            res_p1;

  // Only the operand bytes of the read word are consumed.
  logic unused_rd_hi;
  assign unused_rd_hi = ^mem_data_i[DATA_WIDTH-1:16];

  assign bus_rd   = (state == READ);
  assign bus_wr   = (state == WRITE);
  assign start_ok = (state == IDLE) && start_i;
  // The counter sits at TO_LAST in the TIMEOUT-th cycle of a bus phase.
  assign tmo_hit  = (bus_rd || bus_wr) && !mem_ack_i && (tmo_cnt == TO_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = (count_i == '0) ? DONE : READ;
      READ:    if (mem_ack_i) state_next = MULT;
               else if (tmo_hit) state_next = DONE;
      MULT:    state_next = WRITE;
      WRITE:   if (mem_ack_i) state_next = (remain == ONE_LEFT) ? DONE : READ;
               else if (tmo_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control: state, timeout counter, error flag, operand register (drives
  // mul_*_o directly, so it must come out of reset at zero).
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      err     <= 1'b0;
      opnd_p0 <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || !(bus_rd || bus_wr))
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 4'd1;
      if (start_ok)
        err <= 1'b0;
      else if (tmo_hit)
        err <= 1'b1;
      if (bus_rd && mem_ack_i)
        opnd_p0 <= mem_data_i[15:0];
    end
  end

  // Datapath: pointer, element count, product register. Their values only
  // reach outputs while the bus is active, so they carry no reset.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      ptr    <= base_adr_i;
      remain <= count_i;
    end else if (bus_wr && mem_ack_i) begin
      ptr    <= ptr + ADDR_WIDTH'(1);
      remain <= remain - ONE_LEFT;
    end
    if (state == MULT)
      res_p1 <= mul_prod_i;
  end

`ifdef FF256_SEQ_ACCUM_EN
  logic [7:0] acc;

  always_ff @(posedge clk) begin
    if (reset)
      acc <= '0;
    else if (start_ok)
      acc <= '0;
    else if (bus_wr && mem_ack_i)
      acc <= acc ^ res_p1;
  end

  assign acc_o = acc;
`else
  assign acc_o = 8'h00;
`endif

  assign mem_stb_o  = bus_rd || bus_wr;
  assign mem_cyc_o  = bus_rd || bus_wr;
  assign mem_we_o   = bus_wr;
  assign mem_adr_o  = (bus_rd || bus_wr) ? ptr : '0;
  assign mem_sel_o  = bus_rd ? {SEL_W{1'b1}} : (bus_wr ? SEL_WR : '0);
  assign mem_data_o = bus_wr ? DATA_WIDTH'({res_p1, 16'h0000}) : '0;

  assign mul_f_o = opnd_p0[7:0];
  assign mul_p_o = opnd_p0[15:8];

  assign busy_o  = (state != IDLE);
  assign done_o  = (state == DONE);
  assign err_o   = err;
  assign state_o = state;

endmodule
